// File: rtl/imm_operand_encoder_pkg.sv
// Shared constants for the immediate operand encoder.
// Type codes match the decode-stage immediate generator.
package imm_operand_encoder_pkg;

  localparam logic [2:0] ITYPE = 3'd1;
  localparam logic [2:0] STYPE = 3'd2;
  localparam logic [2:0] BTYPE = 3'd3;
  localparam logic [2:0] UTYPE = 3'd4;
  localparam logic [2:0] JTYPE = 3'd5;

  localparam int IMMERR_RANGE = 0;
  localparam int IMMERR_TYPE  = 1;

  // Field masks in instruction bits [31:7] view.
  localparam logic [24:0] MASK_I  = 25'h1FFE000;
  localparam logic [24:0] MASK_SB = 25'h1FC001F;
  localparam logic [24:0] MASK_UJ = 25'h1FFFFE0;

endpackage

// File: rtl/imm_operand_encoder_range_check.sv
// Flags immediates that do not fit their format and unknown types.
// Purely combinational.
module imm_range_check
  import imm_operand_encoder_pkg::*;
(
  input  logic [31:0] i_imm,
  input  logic [2:0]  i_type,
  output logic [1:0]  o_err
);

  logic w_s11;
  logic w_s12;
  logic w_s20;

  assign w_s11 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_s12 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign w_s20 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

  always_comb begin
    o_err = '0;
    case (i_type)
      ITYPE, STYPE:
        o_err[IMMERR_RANGE] = ~w_s11;
      BTYPE:
        o_err[IMMERR_RANGE] = ~w_s12 | i_imm[0];
      JTYPE:
        o_err[IMMERR_RANGE] = ~w_s20 | i_imm[0];
      UTYPE:
        o_err[IMMERR_RANGE] = |i_imm[11:0];
      default:
        o_err[IMMERR_TYPE] = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_operand_encoder.sv
// Packs a 32-bit immediate into instruction bits [31:7].
// Two-stage valid/ready pipeline with saturating error count.
module imm_operand_encoder
  import imm_operand_encoder_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_imm,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      out_field,
  output logic [24:0]      out_mask,
  output logic [1:0]       out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] err_count,
  input  logic             cnt_clr
);

  logic             r_s1_valid;
  logic [31:0]      r_s1_imm;
  logic [2:0]       r_s1_type;
  logic [TAG_W-1:0] r_s1_tag;
  logic [1:0]       r_s1_err;

  logic             r_s2_valid;
  logic [24:0]      r_field;
  logic [24:0]      r_mask;
  logic [1:0]       r_err;
  logic [TAG_W-1:0] r_tag;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s2_adv;
  logic             w_out_fire;
  logic [1:0]       w_chk_err;
  logic [24:0]      w_fld;
  logic [24:0]      w_msk;

  assign w_s2_adv   = ~r_s2_valid | out_ready;
  assign in_ready   = ~r_s1_valid | w_s2_adv;
  assign w_out_fire = r_s2_valid & out_ready;

  assign out_valid  = r_s2_valid;
  assign out_field  = r_field;
  assign out_mask   = r_mask;
  assign out_err    = r_err;
  assign out_tag    = r_tag;
  assign err_count  = r_cnt;

  imm_range_check u_chk (
    .i_imm  (in_imm),
    .i_type (in_type),
    .o_err  (w_chk_err)
  );

  // Field index k is instruction bit k+7.
  always_comb begin
    w_fld = '0;
    w_msk = '0;
    case (r_s1_type)
      ITYPE: begin
        w_fld[24:13] = r_s1_imm[11:0];
        w_msk        = MASK_I;
      end
      STYPE: begin
        w_fld[24:18] = r_s1_imm[11:5];
        w_fld[4:0]   = r_s1_imm[4:0];
        w_msk        = MASK_SB;
      end
      BTYPE: begin
        w_fld[24]    = r_s1_imm[12];
        w_fld[23:18] = r_s1_imm[10:5];
        w_fld[4:1]   = r_s1_imm[4:1];
        w_fld[0]     = r_s1_imm[11];
        w_msk        = MASK_SB;
      end
      UTYPE: begin
        w_fld[24:5]  = r_s1_imm[31:12];
        w_msk        = MASK_UJ;
      end
      JTYPE: begin
        w_fld[24]    = r_s1_imm[20];
        w_fld[23:14] = r_s1_imm[10:1];
        w_fld[13]    = r_s1_imm[11];
        w_fld[12:5]  = r_s1_imm[19:12];
        w_msk        = MASK_UJ;
      end
      default: begin
        w_fld = '0;
        w_msk = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_imm   <= '0;
      r_s1_type  <= '0;
      r_s1_tag   <= '0;
      r_s1_err   <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_imm  <= in_imm;
        r_s1_type <= in_type;
        r_s1_tag  <= in_tag;
        r_s1_err  <= w_chk_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_field    <= '0;
      r_mask     <= '0;
      r_err      <= '0;
      r_tag      <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_field <= w_fld;
        r_mask  <= w_msk;
        r_err   <= r_s1_err;
        r_tag   <= r_s1_tag;
      end
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_out_fire && (|r_err)) begin
      if (!(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Random and directed checks of imm_operand_encoder
// against a decode-side reference model.
module tb_imm_operand_encoder;
  import imm_operand_encoder_pkg::*;

  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_imm;
  logic [2:0]       in_type;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [24:0]      out_field;
  logic [24:0]      out_mask;
  logic [1:0]       out_err;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] err_count;
  logic             cnt_clr;

  always #5 clk = ~clk;

  imm_operand_encoder #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_type   (in_type),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_mask  (out_mask),
    .out_err   (out_err),
    .out_tag   (out_tag),
    .err_count (err_count),
    .cnt_clr   (cnt_clr)
  );

  typedef struct {
    logic [2:0]  ty;
    logic [3:0]  tag;
    logic [1:0]  err;
    logic [31:0] msk;
    logic [31:0] dec;
    bit          has_ins;
    logic [31:0] ins;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_chk = 0;
  int   n_fail = 0;
  int   mcnt = 0;
  int   acc = 0;
  int   fires = 0;
  bit   in_fire, out_fire;
  bit   hold = 0;
  logic [24:0] h_fld, h_msk;
  logic [1:0]  h_err;
  logic [3:0]  h_tag;

  task automatic chk(input string t, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", t, obs, exp);
    end
  endtask

  function automatic longint wrap(longint v, int n);
    longint m = 64'sd1 <<< n;
    longint r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  // Standard RV32I immediate generator.
  function automatic logic [31:0] dec_imm(logic [31:0] x,
                                          logic [2:0] ty);
    case (ty)
      ITYPE: return {{20{x[31]}}, x[31:20]};
      STYPE: return {{20{x[31]}}, x[31:25], x[11:7]};
      BTYPE: return {{19{x[31]}}, x[31], x[7], x[30:25],
                     x[11:8], 1'b0};
      UTYPE: return {x[31:12], 12'b0};
      JTYPE: return {{11{x[31]}}, x[31], x[19:12], x[20],
                     x[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic exp_t model(logic [31:0] imm, logic [2:0] ty,
                                 logic [3:0] tag);
    exp_t   e;
    longint s = longint'($signed(imm));
    bit     ok = 1;
    e.ty = ty; e.tag = tag; e.err = 2'b00;
    e.msk = 0; e.dec = 0; e.has_ins = 0; e.ins = 0;
    case (ty)
      ITYPE, STYPE: begin
        ok = (s >= -2048) && (s <= 2047);
        e.dec = 32'(wrap(s, 12));
        e.msk = (ty == ITYPE) ? 32'hFFF00000 : 32'hFE000F80;
      end
      BTYPE: begin
        ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        e.dec = 32'(wrap(s & ~64'sd1, 13));
        e.msk = 32'hFE000F80;
      end
      JTYPE: begin
        ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
        e.dec = 32'(wrap(s & ~64'sd1, 21));
        e.msk = 32'hFFFFF000;
      end
      UTYPE: begin
        ok = (imm % 4096 == 0);
        e.dec = imm - (imm % 4096);
        e.msk = 32'hFFFFF000;
      end
      default: e.err = 2'b10;
    endcase
    if (!ok) e.err = 2'b01;
    return e;
  endfunction

  task automatic present(input logic [31:0] imm, input logic [2:0] ty,
                         input logic [3:0] tag, input bit has,
                         input logic [31:0] ins);
    in_valid = 1'b1;
    in_imm = imm;
    in_type = ty;
    in_tag = tag;
    cur = model(imm, ty, tag);
    cur.has_ins = has;
    cur.ins = ins;
  endtask

  task automatic cyc();
    exp_t e;
    logic [31:0] f;
    @(negedge clk);
    chk("cnt", 32'(err_count), 32'(mcnt));
    if (hold) begin
      chk("hold_v", 32'(out_valid), 32'd1);
      chk("hold_f", 32'(out_field), 32'(h_fld));
      chk("hold_m", 32'(out_mask), 32'(h_msk));
      chk("hold_e", 32'(out_err), 32'(h_err));
      chk("hold_t", 32'(out_tag), 32'(h_tag));
    end
    in_fire = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (out_fire) begin
      if (q.size() == 0) begin
        chk("spurious", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        f = {out_field, 7'b0};
        chk("err", 32'(out_err), 32'(e.err));
        chk("tag", 32'(out_tag), 32'(e.tag));
        chk("mask", {out_mask, 7'b0}, e.msk);
        chk("spill", {out_field & ~out_mask, 7'b0}, 32'h0);
        if (e.err[1]) chk("fld0", f, 32'h0);
        else chk("rt", dec_imm(f, e.ty), e.dec);
        if (e.has_ins) chk("ins", f, e.ins);
      end
      fires++;
    end
    if (cnt_clr) mcnt = 0;
    else if (out_fire && out_err != 0 && mcnt < 65535) mcnt++;
    if (in_fire) begin
      q.push_back(cur);
      acc++;
    end
    hold = out_valid && !out_ready;
    h_fld = out_field; h_msk = out_mask;
    h_err = out_err; h_tag = out_tag;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) cyc();
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic send(input int budget);
    int k = 0;
    do begin
      cyc();
      k++;
    end while (!in_fire && k < budget);
    chk("acc_to", 32'(in_fire), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    mcnt = 0;
    hold = 0;
  endtask

  logic [31:0] bp_imm [4];
  logic [2:0]  bp_ty  [4];
  logic [31:0] r_imm;
  logic [2:0]  r_ty;
  int          idx, acc0, f0, sent, sel;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_imm = '0; in_type = '0;
    in_tag = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v", 32'(out_valid), 32'd0);
    chk("rst_f", 32'(out_field), 32'd0);
    chk("rst_m", 32'(out_mask), 32'd0);
    chk("rst_e", 32'(out_err), 32'd0);
    chk("rst_t", 32'(out_tag), 32'd0);
    chk("rst_c", 32'(err_count), 32'd0);
    rst = 1'b0;

    // Latency and all-ones I immediate.
    out_ready = 1'b1;
    present(32'hFFFFFFFF, ITYPE, 4'd1, 1, 32'hFFF00000);
    cyc();
    chk("acc1", 32'(in_fire), 32'd1);
    in_valid = 1'b0;
    chk("lat1", 32'(out_valid), 32'd0);
    cyc();
    chk("lat2", 32'(out_valid), 32'd1);
    cyc();

    // Back-to-back stream.
    f0 = fires;
    present(32'h000007FF, STYPE, 4'd2, 1, 32'h7E000F80);
    cyc();
    present(32'h00000800, BTYPE, 4'd3, 1, 32'h00000080);
    cyc();
    chk("b2b0", 32'(fires - f0), 32'd0);
    present(32'h12345000, UTYPE, 4'd4, 1, 32'h12345000);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    chk("b2b3", 32'(fires - f0), 32'd3);
    drain();

    // Error cases.
    present(32'h00100000, JTYPE, 4'd5, 0, 0);
    send(4);
    cyc(); cyc(); cyc();
    chk("cnt1", 32'(err_count), 32'd1);
    present(32'h00000003, BTYPE, 4'd6, 0, 0);
    cyc();
    present(32'h00000123, 3'd0, 4'd7, 0, 0);
    cyc();
    drain();

    // Backpressure with 4 items offered.
    bp_imm[0] = 32'h00000010; bp_ty[0] = ITYPE;
    bp_imm[1] = 32'hFFFFF800; bp_ty[1] = STYPE;
    bp_imm[2] = 32'h00000801; bp_ty[2] = JTYPE;
    bp_imm[3] = 32'hABCDE000; bp_ty[3] = UTYPE;
    out_ready = 1'b0;
    idx = 0;
    acc0 = acc;
    present(bp_imm[0], bp_ty[0], 4'd8, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (in_fire) begin
        idx++;
        if (idx < 4) present(bp_imm[idx], bp_ty[idx], 4'(8 + idx), 0, 0);
        else in_valid = 1'b0;
      end
    end
    chk("bp_acc", 32'(acc - acc0), 32'd2);
    chk("bp_rdy", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && idx < 4; i++) begin
      cyc();
      if (in_fire) begin
        idx++;
        if (idx < 4) present(bp_imm[idx], bp_ty[idx], 4'(8 + idx), 0, 0);
        else in_valid = 1'b0;
      end
    end
    chk("bp_all", 32'(idx), 32'd4);
    drain();

    // Reset with two items in flight.
    out_ready = 1'b0;
    acc0 = acc;
    present(32'h00000055, ITYPE, 4'd12, 0, 0);
    for (int i = 0; i < 4 && acc - acc0 < 2; i++) cyc();
    chk("fl2", 32'(acc - acc0), 32'd2);
    do_reset();
    chk("rs_v", 32'(out_valid), 32'd0);
    chk("rs_c", 32'(err_count), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stale", 32'(out_valid), 32'd0);
    end

    // Clear coincident with an error handshake.
    present(32'h00000001, UTYPE, 4'd13, 0, 0);
    send(4);
    cyc(); cyc(); cyc();
    chk("pre_clr", 32'(err_count), 32'd1);
    out_ready = 1'b0;
    present(32'h00000FFF, UTYPE, 4'd14, 0, 0);
    send(4);
    cyc(); cyc();
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    cyc();
    chk("clr_fire", 32'(out_fire), 32'd1);
    cnt_clr = 1'b0;
    cyc();
    chk("clr", 32'(err_count), 32'd0);

    // Random round-trip, mostly legal values.
    sent = 0;
    while (sent < 11000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        sel = $urandom_range(0, 10);
        case ($urandom_range(0, 4))
          0: r_ty = ITYPE;
          1: r_ty = STYPE;
          2: r_ty = BTYPE;
          3: r_ty = UTYPE;
          default: r_ty = JTYPE;
        endcase
        case (r_ty)
          ITYPE, STYPE: r_imm = $urandom_range(0, 4095) - 2048;
          BTYPE: r_imm = ($urandom_range(0, 4095) - 2048) * 2;
          JTYPE: r_imm = ($urandom_range(0, 1048575) - 524288) * 2;
          default: r_imm = $urandom & 32'hFFFFF000;
        endcase
        if (sel == 0) begin
          r_ty = 3'($urandom_range(0, 7));
          r_imm = ($urandom_range(0, 1) != 0) ? $urandom :
                  32'($urandom_range(0, 8191)) - 32'd4096;
        end
        present(r_imm, r_ty, 4'($urandom), 0, 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr = ($urandom_range(0, 499) == 0);
      cyc();
      if (in_fire) begin
        in_valid = 1'b0;
        sent++;
      end
    end
    cnt_clr = 1'b0;
    drain();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
